// File: rtl/controle_escrita_reg.sv
// controle_escrita_reg
// Register-file write-back sequencer. Accepts a write-back request from the
// main control, optionally waits for memory read data (bounded by a 4-bit
// wait counter), then issues one or two register-file writes and reports
// completion. Invalid request codes and memory-wait timeouts are flagged
// with single-cycle registered pulses.

module controle_escrita_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciarEscrita,
  input  logic [2:0] tipoEscrita,
  input  logic       dadoPronto,
  output logic [1:0] RegWriteMUX,
  output logic [1:0] selDadoEscrita,
  output logic       RegWrite,
  output logic       ocupado,
  output logic       concluido,
  output logic       erroTipo,
  output logic       erroTimeout
);

  // Write-back kinds carried on tipoEscrita
  localparam logic [2:0] TIPO_R    = 3'b000;
  localparam logic [2:0] TIPO_IALU = 3'b001;
  localparam logic [2:0] TIPO_LOAD = 3'b010;
  localparam logic [2:0] TIPO_JAL  = 3'b011;
  localparam logic [2:0] TIPO_PUSH = 3'b100;
  localparam logic [2:0] TIPO_POP  = 3'b101;

  // Destination register select
  localparam logic [1:0] DEST_RT = 2'b00;
  localparam logic [1:0] DEST_SP = 2'b01;  // register 29
  localparam logic [1:0] DEST_RA = 2'b10;  // register 31
  localparam logic [1:0] DEST_RD = 2'b11;

  // Write-data source select
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;
  localparam logic [1:0] SRC_SP  = 2'b11;

  // Last value of the wait counter before a missing dadoPronto is a timeout
  localparam logic [3:0] ESPERA_MAX = 4'hF;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    AGUARDA_MEM = 3'd1,
    ESCREVE1    = 3'd2,
    ESCREVE2    = 3'd3,
    FIM         = 3'd4
  } estado_t;

  estado_t    state_reg, state_next;
  logic [2:0] tipo_reg, tipo_next;
  logic [3:0] espera_reg, espera_next;
  logic       erro_tipo_reg, erro_tipo_next;
  logic       erro_timeout_reg, erro_timeout_next;

  // Codes 110 and 111 have no defined write-back
  logic tipo_valido;
  assign tipo_valido = (tipoEscrita[2:1] != 2'b11);

  // Only loads and pops need to wait for memory data before writing
  logic precisa_mem;
  assign precisa_mem = (tipoEscrita == TIPO_LOAD) || (tipoEscrita == TIPO_POP);

  // State register plus latched type, wait counter and error pulse flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= OCIOSO;
      tipo_reg         <= 3'b000;
      espera_reg       <= 4'd0;
      erro_tipo_reg    <= 1'b0;
      erro_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tipo_reg         <= tipo_next;
      espera_reg       <= espera_next;
      erro_tipo_reg    <= erro_tipo_next;
      erro_timeout_reg <= erro_timeout_next;
    end
  end

  // Next-state logic: acceptance, memory wait with timeout, write sequencing
  always_comb begin
    state_next        = state_reg;
    tipo_next         = tipo_reg;
    espera_next       = espera_reg;
    erro_tipo_next    = 1'b0;
    erro_timeout_next = 1'b0;
    case (state_reg)
      OCIOSO: begin
        // Requests are only looked at here, so anything raised while busy
        // is simply dropped.
        if (iniciarEscrita) begin
          if (tipo_valido) begin
            tipo_next   = tipoEscrita;
            espera_next = 4'd0;
            state_next  = precisa_mem ? AGUARDA_MEM : ESCREVE1;
          end else begin
            erro_tipo_next = 1'b1;
          end
        end
      end
      AGUARDA_MEM: begin
        // Data arriving on the last allowed cycle still wins over timeout
        if (dadoPronto) begin
          state_next = ESCREVE1;
        end else if (espera_reg == ESPERA_MAX) begin
          state_next        = OCIOSO;
          erro_timeout_next = 1'b1;
        end else begin
          espera_next = espera_reg + 4'd1;
        end
      end
      ESCREVE1: begin
        state_next = (tipo_reg == TIPO_POP) ? ESCREVE2 : FIM;
      end
      ESCREVE2: begin
        state_next = FIM;
      end
      FIM: begin
        state_next = OCIOSO;
      end
      default: begin
        state_next = OCIOSO;
      end
    endcase
  end

  // Moore output decode from the current state and the latched type
  always_comb begin
    RegWrite       = 1'b0;
    RegWriteMUX    = DEST_RT;
    selDadoEscrita = SRC_ALU;
    ocupado        = (state_reg != OCIOSO);
    concluido      = (state_reg == FIM);
    case (state_reg)
      ESCREVE1: begin
        RegWrite = 1'b1;
        case (tipo_reg)
          TIPO_R: begin
            RegWriteMUX    = DEST_RD;
            selDadoEscrita = SRC_ALU;
          end
          TIPO_IALU: begin
            RegWriteMUX    = DEST_RT;
            selDadoEscrita = SRC_ALU;
          end
          TIPO_LOAD: begin
            RegWriteMUX    = DEST_RT;
            selDadoEscrita = SRC_MEM;
          end
          TIPO_JAL: begin
            RegWriteMUX    = DEST_RA;
            selDadoEscrita = SRC_PC;
          end
          TIPO_PUSH: begin
            RegWriteMUX    = DEST_SP;
            selDadoEscrita = SRC_SP;
          end
          TIPO_POP: begin
            // First half of a pop: the loaded value goes to rt
            RegWriteMUX    = DEST_RT;
            selDadoEscrita = SRC_MEM;
          end
          default: begin
            RegWriteMUX    = DEST_RT;
            selDadoEscrita = SRC_ALU;
          end
        endcase
      end
      ESCREVE2: begin
        // Second half of a pop: stack pointer adjust
        RegWrite       = 1'b1;
        RegWriteMUX    = DEST_SP;
        selDadoEscrita = SRC_SP;
      end
      default: begin
        RegWrite       = 1'b0;
        RegWriteMUX    = DEST_RT;
        selDadoEscrita = SRC_ALU;
      end
    endcase
  end

  // Error pulses come straight from their flops
  assign erroTipo    = erro_tipo_reg;
  assign erroTimeout = erro_timeout_reg;

endmodule

// File: doc/controle_escrita_reg.md
CONTROLE_ESCRITA_REG -- requirements
Module: controle_escrita_reg

Interface
REQ-001 The module SHALL have the port `clk`: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-002 The module SHALL have the port `reset`: input, 1 bit, a synchronous active-low reset.
REQ-003 The module SHALL have the port `iniciarEscrita`: input, 1 bit, a write-back request from the main control; it SHALL be sampled only in OCIOSO.
REQ-004 The module SHALL have the port `tipoEscrita`: input, 3 bits, the write-back kind; it SHALL be latched together with an accepted request.
REQ-005 The module SHALL have the port `dadoPronto`: input, 1 bit, memory read data valid; it SHALL be sampled only in AGUARDA_MEM.
REQ-006 The module SHALL have the port `RegWriteMUX`: output, 2 bits, the destination select: 00 = rt, 01 = reg 29, 10 = reg 31, 11 = rd.
REQ-007 The module SHALL have the port `selDadoEscrita`: output, 2 bits, the write-data source: 00 = ALU, 01 = memory, 10 = PC, 11 = SP adjust.
REQ-008 The module SHALL have the port `RegWrite`: output, 1 bit, the register-file write enable.
REQ-009 The module SHALL have the port `ocupado`: output, 1 bit, high in every state except OCIOSO.
REQ-010 The module SHALL have the port `concluido`: output, 1 bit, a 1-cycle pulse when a sequence finishes.
REQ-011 The module SHALL have the port `erroTipo`: output, 1 bit, a 1-cycle pulse for an invalid tipoEscrita.
REQ-012 The module SHALL have the port `erroTimeout`: output, 1 bit, a 1-cycle pulse for a memory-wait timeout.

Function
REQ-013 The module SHALL implement the states OCIOSO, AGUARDA_MEM, ESCREVE1, ESCREVE2 and FIM.
REQ-014 The tipoEscrita codes SHALL be:
- 000 R (rd, ALU)
- 001 I-ALU (rt, ALU)
- 010 LOAD (rt, memory)
- 011 JAL (31, PC)
- 100 PUSH (29, SP)
- 101 POP (rt, memory, then 29, SP)
- 110 and 111 invalid
REQ-015 Acceptance SHALL occur when, in OCIOSO at cycle T, iniciarEscrita=1 and the code is valid; tipoEscrita SHALL be latched at that edge.
REQ-016 For R, I-ALU, JAL and PUSH, the state SHALL be ESCREVE1 at T+1 and FIM at T+2, then OCIOSO at T+3.
REQ-017 For LOAD and POP, the state SHALL be AGUARDA_MEM from T+1.
REQ-018 In AGUARDA_MEM, dadoPronto=1 at cycle W SHALL give ESCREVE1 at W+1; dadoPronto=1 already at T+1 SHALL be valid.
REQ-019 The wait counter SHALL be 4 bits, cleared on acceptance, and incremented in each AGUARDA_MEM cycle with dadoPronto=0.
REQ-020 When the wait counter equals 15 and dadoPronto=0, the state SHALL return to OCIOSO with erroTimeout=1 for the next cycle; no write and no concluido SHALL occur.
REQ-021 dadoPronto=1 in the same cycle the counter equals 15 SHALL take priority over timeout and proceed to ESCREVE1.
REQ-022 In ESCREVE1, RegWrite SHALL be 1 and RegWriteMUX/selDadoEscrita SHALL be set per the latched type:
- R: 11/00
- I-ALU: 00/00
- LOAD: 00/01
- JAL: 10/10
- PUSH: 01/11
- POP: 00/01
REQ-023 For POP, ESCREVE1 SHALL be followed by ESCREVE2 (RegWrite=1, RegWriteMUX=01, selDadoEscrita=11) and then FIM; all other types SHALL go from ESCREVE1 to FIM.
REQ-024 The total number of RegWrite=1 cycles per accepted sequence SHALL be exactly 1, or exactly 2 for POP.
REQ-025 Outside ESCREVE1 and ESCREVE2, RegWrite SHALL be 0 and RegWriteMUX and selDadoEscrita SHALL be 00.
REQ-026 RegWrite, RegWriteMUX, selDadoEscrita and ocupado SHALL be Moore outputs decoded from state and the latched type.
REQ-027 In FIM, concluido SHALL be 1 and ocupado SHALL be 1; the next state SHALL always be OCIOSO.
REQ-028 iniciarEscrita while ocupado=1 SHALL be ignored, with no queuing and no error.
REQ-029 An invalid code with iniciarEscrita=1 in OCIOSO SHALL keep the state at OCIOSO and drive erroTipo=1 for exactly the next cycle.
REQ-030 erroTipo and erroTimeout SHALL be registered pulses and SHALL never both be 1.
REQ-031 The earliest new acceptance after concluido SHALL be the cycle following FIM, which is OCIOSO.

Reset
REQ-032 reset=0 at a rising edge SHALL force OCIOSO, clear the wait counter, the latched type and all pulse registers, and take priority over all inputs.
REQ-033 While in reset and on the first cycle after it, all outputs SHALL be 0.
REQ-034 Reset during AGUARDA_MEM, ESCREVE1, ESCREVE2 or FIM SHALL abort the sequence with no further RegWrite and no concluido.

Verification
REQ-035 The bench SHALL verify R: iniciarEscrita=1, tipo=000 at T -> T+1 RegWrite=1, MUX=11, sel=00; T+2 concluido=1; T+3 ocupado=0.
REQ-036 The bench SHALL verify POP with dadoPronto=1 at T+3:
- T+4: RegWrite=1, MUX=00, sel=01
- T+5: RegWrite=1, MUX=01, sel=11
- T+6: concluido=1
REQ-037 The bench SHALL verify LOAD timeout: dadoPronto held 0 -> 16 AGUARDA_MEM cycles, erroTimeout=1 once, RegWrite never 1, then OCIOSO.
REQ-038 The bench SHALL verify the boundary: dadoPronto=1 in the 16th wait cycle -> normal write, no erroTimeout.
REQ-039 The bench SHALL verify tipo=110 with request -> erroTipo=1 for 1 cycle, ocupado stays 0, RegWrite stays 0.
REQ-040 The bench SHALL verify JAL with reset=0 asserted at T+1 -> no concluido, all outputs 0 at T+2, and a new JAL accepted normally after reset is released.
